// File: rtl/debounce_sync.sv
// debounce_sync: conditions a raw asynchronous input (button/switch) for the
// D flip-flop downstream. din is brought into clk through a 2-flop
// synchronizer. A stability counter plus FSM then filters glitches and
// produces a clean registered level (dout) with one-clock rise/fall pulses.
//
// Optional build macro: DEBOUNCE_EVT_CNT_EN
//   When defined, adds output evt_cnt[7:0]. It counts every rise/fall pulse,
//   wraps 255->0, and updates on the same edge as the pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// LO_STABLE | dout=0, synchronized input agrees with dout
// LO_PEND   | dout=0, a 1 has been seen, counting consecutive 1s
// HI_STABLE | dout=1, synchronized input agrees with dout
// HI_PEND   | dout=1, a 0 has been seen, counting consecutive 0s
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       dout,
    output logic       rise,
    output logic       fall
`ifdef DEBOUNCE_EVT_CNT_EN
    ,
    output logic [7:0] evt_cnt
`endif
);

    // Reject parameter sets the counter cannot represent.
    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("debounce_sync: STABLE_CYCLES must be 2 or more");
    end
    if ((1 << CNT_W) <= (STABLE_CYCLES - 1)) begin : g_bad_cnt_w
        $error("debounce_sync: CNT_W too narrow for STABLE_CYCLES-1");
    end

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Value of cnt on the last differing edge before dout is allowed to follow.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LO_STABLE = 2'b00,
        LO_PEND   = 2'b01,
        HI_STABLE = 2'b10,
        HI_PEND   = 2'b11
    } state_t;

    logic             sync1_d, sync1_q;
    logic             sync2_d, sync2_q;
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d,   cnt_q;
    logic             dout_d,  dout_q;
    logic             rise_d,  rise_q;
    logic             fall_d,  fall_q;
    logic             differ;

    // Synchronizer next values: sync1 samples the raw pin, sync2 re-times it.
    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
    end

    // Synchronizer flops; only sync2 is ever looked at by the filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign differ = (sync2_q != dout_q);

    // Debounce next-state: count consecutive disagreeing samples and follow
    // only after STABLE_CYCLES of them; any agreeing sample is a bounce.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LO_STABLE: begin
                if (differ) begin
                    state_d = LO_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            HI_STABLE: begin
                if (differ) begin
                    state_d = HI_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = CNT_ZERO;
                end
            end
            LO_PEND: begin
                if (!differ) begin
                    state_d = LO_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HI_STABLE;
                    cnt_d   = CNT_ZERO;
                    dout_d  = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            HI_PEND: begin
                if (!differ) begin
                    state_d = HI_STABLE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LO_STABLE;
                    cnt_d   = CNT_ZERO;
                    dout_d  = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = LO_STABLE;
                cnt_d   = CNT_ZERO;
                dout_d  = 1'b0;
            end
        endcase
    end

    // FSM, counter and output registers; reset discards any pending change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LO_STABLE;
            cnt_q   <= CNT_ZERO;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef DEBOUNCE_EVT_CNT_EN
    logic [7:0] evt_cnt_d, evt_cnt_q;

    // Event count advances on the same edge that raises a pulse; wraps freely.
    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (rise_d || fall_d) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    // Event counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_cnt_q <= 8'd0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
`timescale 1ns/1ps
module tb_debounce_sync;
    localparam int STABLE = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic dout, rise, fall;
`ifdef DEBOUNCE_EVT_CNT_EN
    logic [7:0] evt_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int rise_seen = 0;
    int fall_seen = 0;

    always #5 clk = ~clk;

    debounce_sync #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .rise (rise),
        .fall (fall)
`ifdef DEBOUNCE_EVT_CNT_EN
        ,
        .evt_cnt (evt_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the filter sees din as sampled two edges earlier, and
    // dout follows once the last STABLE observed samples all disagree with it.
    bit m_d1, m_d2;
    bit m_win [STABLE];
    bit m_dout, m_rise, m_fall;
    int m_evt;
    bit m_seen, m_tog;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_d1 = 0; m_d2 = 0;
            for (int i = 0; i < STABLE; i++) m_win[i] = 0;
            m_dout = 0; m_rise = 0; m_fall = 0; m_evt = 0;
        end else begin
            m_seen = m_d2;
            m_d2 = m_d1;
            m_d1 = din;
            for (int i = STABLE - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = m_seen;
            m_tog = 1;
            for (int i = 0; i < STABLE; i++) if (m_win[i] == m_dout) m_tog = 0;
            m_rise = m_tog && !m_dout;
            m_fall = m_tog && m_dout;
            if (m_tog) begin
                m_dout = !m_dout;
                m_evt = (m_evt + 1) % 256;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("dout_vs_model", {31'd0, dout}, {31'd0, m_dout});
        chk("rise_vs_model", {31'd0, rise}, {31'd0, m_rise});
        chk("fall_vs_model", {31'd0, fall}, {31'd0, m_fall});
`ifdef DEBOUNCE_EVT_CNT_EN
        chk("evt_vs_model", {24'd0, evt_cnt}, m_evt);
`endif
        if (rise === 1'b1) rise_seen++;
        if (fall === 1'b1) fall_seen++;
    end

    int rs0, fs0;

    initial begin
        // Reset then idle
        #12 rst = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        chk("idle_dout", {31'd0, dout}, 32'd0);
        chk("idle_pulses", rise_seen + fall_seen, 32'd0);

        // Clean press: din set before E0, dout at E0+5
        din = 1'b1;
        repeat (5) @(negedge clk);
        chk("press_dout_early", {31'd0, dout}, 32'd0);
        @(negedge clk);
        chk("press_dout", {31'd0, dout}, 32'd1);
        chk("press_rise", {31'd0, rise}, 32'd1);
        chk("press_fall", {31'd0, fall}, 32'd0);
        @(negedge clk);
        chk("press_rise_off", {31'd0, rise}, 32'd0);

        // Release
        din = 1'b0;
        repeat (5) @(negedge clk);
        chk("release_dout_early", {31'd0, dout}, 32'd1);
        @(negedge clk);
        chk("release_dout", {31'd0, dout}, 32'd0);
        chk("release_fall", {31'd0, fall}, 32'd1);
        chk("release_rise", {31'd0, rise}, 32'd0);
        @(negedge clk);
        chk("release_fall_off", {31'd0, fall}, 32'd0);

        // Bounce rejection
        repeat (4) @(negedge clk);
        #1;
        rs0 = rise_seen; fs0 = fall_seen;
        repeat (3) begin
            din = 1'b1; repeat (2) @(negedge clk);
            din = 1'b0; repeat (2) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        #1;
        chk("bounce_dout", {31'd0, dout}, 32'd0);
        chk("bounce_pulses", (rise_seen - rs0) + (fall_seen - fs0), 32'd0);
        din = 1'b1;
        repeat (5) @(negedge clk);
        chk("bounce_final_early", {31'd0, dout}, 32'd0);
        @(negedge clk);
        chk("bounce_final_dout", {31'd0, dout}, 32'd1);
        chk("bounce_final_rise", {31'd0, rise}, 32'd1);

        // Async reset while dout=1 clears outputs before the next edge
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_hi_dout", {31'd0, dout}, 32'd0);
        chk("rst_hi_pulse", {30'd0, rise, fall}, 32'd0);
        din = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);

        // Async reset mid LO_PEND (cnt=2 after E3)
        din = 1'b1;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_pend_dout", {31'd0, dout}, 32'd0);
        chk("rst_pend_pulse", {30'd0, rise, fall}, 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        rs0 = rise_seen;
        repeat (5) @(negedge clk);
        chk("post_rst_dout_early", {31'd0, dout}, 32'd0);
        @(negedge clk);
        chk("post_rst_dout", {31'd0, dout}, 32'd1);
        chk("post_rst_rise", {31'd0, rise}, 32'd1);
        repeat (4) @(negedge clk);
        #1;
        chk("post_rst_rise_once", rise_seen - rs0, 32'd1);

        // Randomized stimulus with occasional async reset pulses
        for (int seg = 0; seg < 400; seg++) begin
            int hold;
            @(negedge clk);
            if ($urandom_range(0, 59) == 0) begin
                #($urandom_range(1, 3));
                rst = 1'b1;
                #10 rst = 1'b0;
            end else begin
                #($urandom_range(0, 3));
                din = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 7);
                repeat (hold - 1) @(negedge clk);
            end
        end

`ifdef DEBOUNCE_EVT_CNT_EN
        // Event counter: 3 press/release pairs, then preload and wrap
        @(negedge clk);
        #1 rst = 1'b1;
        din = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) begin
            din = 1'b1; repeat (8) @(negedge clk);
            din = 1'b0; repeat (8) @(negedge clk);
        end
        chk("evt_six", {24'd0, evt_cnt}, 32'd6);
        for (int k = 0; k < 249; k++) begin
            din = ~din; repeat (7) @(negedge clk);
        end
        chk("evt_255", {24'd0, evt_cnt}, 32'd255);
        din = ~din; repeat (7) @(negedge clk);
        chk("evt_wrap", {24'd0, evt_cnt}, 32'd0);
`endif

        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
